// File: rtl/receptor_pkg.sv
// Shared state codes and command opcodes for the Arduino command receiver.
// State PARIDADE exists only when RECEPTOR_PARIDADE_EN is defined (8E1 framing).
package receptor_pkg;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        INICIO      = 3'd1,
        DADOS       = 3'd2,
        PARADA      = 3'd3,
        DECODIFICA  = 3'd4,
        ESPERA_IDLE = 3'd5
`ifdef RECEPTOR_PARIDADE_EN
        ,
        PARIDADE    = 3'd6
`endif
    } estado_t;

    localparam logic [3:0] OP_DIREITA  = 4'h1;
    localparam logic [3:0] OP_ESQUERDA = 4'h2;
    localparam logic [3:0] OP_ENTER    = 4'h3;
    localparam logic [3:0] OP_NOTA_ON  = 4'h4;
    localparam logic [3:0] OP_NOTA_OFF = 4'h5;
    localparam logic [3:0] OP_LIMPA    = 4'h6;

endpackage

// File: rtl/uart_rx_serial.sv
// UART receiver: two-flop synchroniser, baud counter, framing FSM and shift register.
// Frame is 8N1, or 8E1 when RECEPTOR_PARIDADE_EN is defined.
module uart_rx_serial #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       erro_quadro,
    output logic [2:0] db_estado
);
    import receptor_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FIM  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MEIO = CNT_W'(CLKS_PER_BIT / 2 - 1);

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       dado_q, dado_d;
    logic             erro_q, erro_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic             rx_prev_q, rx_prev_d;
`ifdef RECEPTOR_PARIDADE_EN
    logic             par_err_q, par_err_d;
`endif

    // Synchroniser and edge-history flops reset to 1 so an idle line is not seen as a start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            dado_q    <= '0;
            erro_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
`ifdef RECEPTOR_PARIDADE_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dado_q    <= dado_d;
            erro_q    <= erro_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
`ifdef RECEPTOR_PARIDADE_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        dado_d    = dado_q;
        erro_d    = 1'b0;
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
`ifdef RECEPTOR_PARIDADE_EN
        par_err_d = par_err_q;
`endif

        case (estado_q)
            OCIOSO: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s_q) begin
                    estado_d = INICIO;
                end
            end
            INICIO: begin
                if (cnt_q == CNT_MEIO) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    estado_d = rx_s_q ? OCIOSO : DADOS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DADOS: begin
                if (cnt_q == CNT_FIM) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef RECEPTOR_PARIDADE_EN
                        estado_d = PARIDADE;
`else
                        estado_d = PARADA;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef RECEPTOR_PARIDADE_EN
            PARIDADE: begin
                if (cnt_q == CNT_FIM) begin
                    cnt_d     = '0;
                    par_err_d = ^{shift_q, rx_s_q};
                    estado_d  = PARADA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            PARADA: begin
                if (cnt_q == CNT_FIM) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        // Line still low: wait for release so a break is not taken as a new start.
                        erro_d   = 1'b1;
                        estado_d = ESPERA_IDLE;
`ifdef RECEPTOR_PARIDADE_EN
                    end else if (par_err_q) begin
                        erro_d   = 1'b1;
                        estado_d = OCIOSO;
`endif
                    end else begin
                        dado_d   = shift_q;
                        estado_d = DECODIFICA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODIFICA: begin
                estado_d = OCIOSO;
            end
            ESPERA_IDLE: begin
                if (rx_s_q) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_comb begin
        byte_valid  = (estado_q == DECODIFICA);
        byte_data   = dado_q;
        erro_quadro = erro_q;
        db_estado   = estado_q;
    end

endmodule

// File: rtl/receptor_comandos_arduino.sv
// Arduino -> FPGA command receiver: UART deserialiser plus command decoder and held-note register.
// Define RECEPTOR_PARIDADE_EN to receive 8E1 frames instead of 8N1.
module receptor_comandos_arduino #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int NUM_NOTAS  = 13
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [NUM_NOTAS-1:0] botoes,
    output logic                 right_arrow_pressed,
    output logic                 left_arrow_pressed,
    output logic                 enter_pressed,
    output logic                 byte_valid,
    output logic [7:0]           byte_data,
    output logic                 erro_quadro,
    output logic [2:0]           db_estado
);
    import receptor_pkg::*;

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD;

    logic [NUM_NOTAS-1:0] botoes_q, botoes_d;
    logic [3:0]           op;
    logic [3:0]           arg;

    uart_rx_serial #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .erro_quadro(erro_quadro),
        .db_estado  (db_estado)
    );

    assign op  = byte_data[7:4];
    assign arg = byte_data[3:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            botoes_q <= '0;
        end else begin
            botoes_q <= botoes_d;
        end
    end

    // Out-of-range note indices match no loop iteration and are ignored.
    always_comb begin
        botoes_d = botoes_q;
        if (byte_valid) begin
            case (op)
                OP_NOTA_ON: begin
                    for (int i = 0; i < NUM_NOTAS; i++) begin
                        if (int'(arg) == i) begin
                            botoes_d[i] = 1'b1;
                        end
                    end
                end
                OP_NOTA_OFF: begin
                    for (int i = 0; i < NUM_NOTAS; i++) begin
                        if (int'(arg) == i) begin
                            botoes_d[i] = 1'b0;
                        end
                    end
                end
                OP_LIMPA: begin
                    botoes_d = '0;
                end
                default: begin
                    botoes_d = botoes_q;
                end
            endcase
        end
    end

    always_comb begin
        botoes              = botoes_q;
        right_arrow_pressed = byte_valid && (op == OP_DIREITA);
        left_arrow_pressed  = byte_valid && (op == OP_ESQUERDA);
        enter_pressed       = byte_valid && (op == OP_ENTER);
    end

endmodule

// File: tb/tb_receptor_comandos_arduino.sv
// Directed bench for receptor_comandos_arduino at 16 clocks per bit.
// Parity cases run only when RECEPTOR_PARIDADE_EN is defined.
module tb_receptor_comandos_arduino;

    localparam int BIT_CLKS = 16;

    logic        clk;
    logic        reset;
    logic        rx;
    logic [12:0] botoes;
    logic        right_arrow_pressed;
    logic        left_arrow_pressed;
    logic        enter_pressed;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        erro_quadro;
    logic [2:0]  db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    int n_valid = 0, n_right = 0, n_left = 0, n_enter = 0, n_err = 0;
    int b_valid, b_right, b_left, b_enter, b_err;

    receptor_comandos_arduino #(
        .CLOCK_FREQ(160),
        .BAUD      (10),
        .NUM_NOTAS (13)
    ) dut (
        .clock              (clk),
        .reset              (reset),
        .rx                 (rx),
        .botoes             (botoes),
        .right_arrow_pressed(right_arrow_pressed),
        .left_arrow_pressed (left_arrow_pressed),
        .enter_pressed      (enter_pressed),
        .byte_valid         (byte_valid),
        .byte_data          (byte_data),
        .erro_quadro        (erro_quadro),
        .db_estado          (db_estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each pulse output, sampled away from the active edge.
    always @(negedge clk) begin
        if (byte_valid)          n_valid <= n_valid + 1;
        if (right_arrow_pressed) n_right <= n_right + 1;
        if (left_arrow_pressed)  n_left  <= n_left + 1;
        if (enter_pressed)       n_enter <= n_enter + 1;
        if (erro_quadro)         n_err   <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_valid = n_valid;
        b_right = n_right;
        b_left  = n_left;
        b_enter = n_enter;
        b_err   = n_err;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Leaves rx at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef RECEPTOR_PARIDADE_EN
        send_bit(^b);
`endif
        send_bit(stop_bit);
    endtask

`ifdef RECEPTOR_PARIDADE_EN
    task automatic send_byte_bad_par(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b));
        send_bit(1'b1);
    endtask
`endif

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_botoes", 32'(botoes), 32'h0);
        chk("rst_byte_data", 32'(byte_data), 32'h0);
        chk("rst_valid", 32'(byte_valid), 32'h0);
        chk("rst_erro", 32'(erro_quadro), 32'h0);
        chk("rst_estado", 32'(db_estado), 32'h0);
        reset = 1'b1;
        idle(20);

        // Enter command
        mark();
        send_byte(8'h31, 1'b1);
        idle(8);
        chk("enter_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("enter_pulse_cnt", 32'(n_enter - b_enter), 32'd1);
        chk("enter_right_cnt", 32'(n_right - b_right), 32'd0);
        chk("enter_left_cnt", 32'(n_left - b_left), 32'd0);
        chk("enter_byte_data", 32'(byte_data), 32'h31);
        chk("enter_botoes", 32'(botoes), 32'h0);
        chk("enter_erro_cnt", 32'(n_err - b_err), 32'd0);

        // Back-to-back note on/on/off
        mark();
        send_byte(8'h47, 1'b1);
        chk("b2b_botoes_47", 32'(botoes), 32'h0080);
        send_byte(8'h4C, 1'b1);
        chk("b2b_botoes_4C", 32'(botoes), 32'h1080);
        send_byte(8'h57, 1'b1);
        chk("b2b_botoes_57", 32'(botoes), 32'h1000);
        idle(8);
        chk("b2b_valid_cnt", 32'(n_valid - b_valid), 32'd3);
        chk("b2b_erro_cnt", 32'(n_err - b_err), 32'd0);

        // Out-of-range note and unknown opcode
        mark();
        send_byte(8'h4D, 1'b1);
        send_byte(8'h99, 1'b1);
        idle(8);
        chk("ign_valid_cnt", 32'(n_valid - b_valid), 32'd2);
        chk("ign_botoes", 32'(botoes), 32'h1000);
        chk("ign_cmd_cnt", 32'((n_right - b_right) + (n_left - b_left) + (n_enter - b_enter)), 32'd0);
        chk("ign_byte_data", 32'(byte_data), 32'h99);

        // Framing error with held break, then a good left-arrow byte
        mark();
        send_byte(8'h12, 1'b0);
        repeat (40) @(negedge clk);
        chk("brk_estado_hold", 32'(db_estado), 32'd5);
        idle(10);
        chk("brk_estado_idle", 32'(db_estado), 32'd0);
        send_byte(8'h21, 1'b1);
        idle(8);
        chk("brk_erro_cnt", 32'(n_err - b_err), 32'd1);
        chk("brk_right_cnt", 32'(n_right - b_right), 32'd0);
        chk("brk_left_cnt", 32'(n_left - b_left), 32'd1);
        chk("brk_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("brk_byte_data", 32'(byte_data), 32'h21);

        // Short low glitch on an idle line
        mark();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(30);
        chk("glitch_estado", 32'(db_estado), 32'd0);
        chk("glitch_valid_cnt", 32'(n_valid - b_valid), 32'd0);
        chk("glitch_erro_cnt", 32'(n_err - b_err), 32'd0);

        // Reset in the middle of a frame
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_botoes", 32'(botoes), 32'h0);
        chk("midrst_byte_data", 32'(byte_data), 32'h0);
        chk("midrst_estado", 32'(db_estado), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(20);
        send_byte(8'h43, 1'b1);
        idle(4);
        chk("midrst_botoes_43", 32'(botoes), 32'h0008);
        mark();
        send_byte(8'h65, 1'b1);
        idle(8);
        chk("clear_botoes", 32'(botoes), 32'h0);
        chk("clear_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("clear_byte_data", 32'(byte_data), 32'h65);

`ifdef RECEPTOR_PARIDADE_EN
        mark();
        send_byte(8'h41, 1'b1);
        idle(8);
        chk("par_ok_botoes", 32'(botoes), 32'h0002);
        chk("par_ok_erro_cnt", 32'(n_err - b_err), 32'd0);
        mark();
        send_byte_bad_par(8'h51);
        idle(8);
        chk("par_bad_erro_cnt", 32'(n_err - b_err), 32'd1);
        chk("par_bad_valid_cnt", 32'(n_valid - b_valid), 32'd0);
        chk("par_bad_botoes", 32'(botoes), 32'h0002);
        chk("par_bad_estado", 32'(db_estado), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
